// File: rtl/z_writeback_unit_pkg.sv
// Shared ALU opcode map, BusMux destination codes and writeback FSM states.
// Used by the ALU, the control unit and the Z writeback path.
package z_writeback_unit_pkg;

    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001;
    localparam logic [4:0] OpRor  = 5'b01010;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;

    localparam logic [1:0] DestRz = 2'b00;
    localparam logic [1:0] DestLo = 2'b01;
    localparam logic [1:0] DestHi = 2'b10;

    localparam logic [1:0] StIdle   = 2'b00;
    localparam logic [1:0] StBeatLo = 2'b01;
    localparam logic [1:0] StBeatHi = 2'b10;

    typedef struct packed {
        logic legal;
        logic isMuldiv;
    } opClass_t;

endpackage

// File: rtl/z_opcode_decode.sv
// Classifies an ALU opcode: is it defined, and does it yield a two-word (mul/div) result.
module z_opcode_decode
    import z_writeback_unit_pkg::*;
(
    input  logic [4:0] ALUControl,
    output logic       legal,
    output logic       isMuldiv
);

    opClass_t opClass;

    always_comb begin
        opClass = '0;
        case (ALUControl)
            OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol, OpNeg, OpNot: begin
                opClass.legal = 1'b1;
            end
            OpMul, OpDiv: begin
                opClass.legal    = 1'b1;
                opClass.isMuldiv = 1'b1;
            end
            default: opClass = '0;
        endcase
    end

    assign legal    = opClass.legal;
    assign isMuldiv = opClass.isMuldiv;

endmodule

// File: rtl/z_writeback_unit.sv
// Captures the 2*DATA_W ALU result into Zhigh/Zlow and streams it onto BusMux
// as one beat (Rz) or two beats (LO then HI) for mul/div.
module z_writeback_unit
    import z_writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2*DATA_W-1:0] ZMuxIn,
    input  logic [4:0]          ALUControl,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   bus_data,
    output logic [1:0]          bus_dest,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [DATA_W-1:0]   Zhigh,
    output logic [DATA_W-1:0]   Zlow,
    output logic                busy,
    output logic                op_err
);

    logic [1:0]        stateQ, stateD;
    logic              muldivQ, muldivD;
    logic [DATA_W-1:0] zHighQ, zLowQ;
    logic              opErrQ;
    logic              legal, isMuldiv;
    logic              finalBeat, xferIn, xferOut;

    z_opcode_decode uDecode (
        .ALUControl (ALUControl),
        .legal      (legal),
        .isMuldiv   (isMuldiv)
    );

    // The last beat of a result can overlap acceptance of the next one.
    assign finalBeat = ((stateQ == StBeatLo) & ~muldivQ) | (stateQ == StBeatHi);
    assign in_ready  = (stateQ == StIdle) | (finalBeat & bus_ready);
    assign xferIn    = in_valid & in_ready;
    assign bus_valid = (stateQ != StIdle);
    assign xferOut   = bus_valid & bus_ready;

    always_comb begin
        stateD  = stateQ;
        muldivD = muldivQ;
        case (stateQ)
            StBeatLo: begin
                if (xferOut) begin
                    stateD = muldivQ ? StBeatHi : StIdle;
                end
            end
            StBeatHi: begin
                if (xferOut) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
        // An undefined opcode still lands in Z but never reaches the bus.
        if (xferIn) begin
            stateD  = legal ? StBeatLo : StIdle;
            muldivD = legal & isMuldiv;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ  <= StIdle;
            muldivQ <= 1'b0;
            zHighQ  <= '0;
            zLowQ   <= '0;
            opErrQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            muldivQ <= muldivD;
            opErrQ  <= xferIn & ~legal;
            if (xferIn) begin
                zHighQ <= ZMuxIn[2*DATA_W-1:DATA_W];
                zLowQ  <= ZMuxIn[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        bus_data = '0;
        bus_dest = DestRz;
        case (stateQ)
            StBeatLo: begin
                bus_data = zLowQ;
                bus_dest = muldivQ ? DestLo : DestRz;
            end
            StBeatHi: begin
                bus_data = zHighQ;
                bus_dest = DestHi;
            end
            default: begin
                bus_data = '0;
                bus_dest = DestRz;
            end
        endcase
    end

    assign Zhigh  = zHighQ;
    assign Zlow   = zLowQ;
    assign busy   = (stateQ != StIdle);
    assign op_err = opErrQ;

endmodule

// File: doc/z_writeback_unit.md
Z_WRITEBACK_UNIT -- requirements
Module: z_writeback_unit

Interface
REQ-001 Parameter: DATA_W, 32, bus and operand width; the Z result width is 2*DATA_W.
REQ-002 The block SHALL have one clock, clock, and a synchronous active-high reset, reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 ZMuxIn  input  64  ALU result.
REQ-006 ALUControl  input  5  opcode accompanying ZMuxIn.
REQ-007 in_valid  input  1  ZMuxIn/ALUControl valid this cycle.
REQ-008 in_ready  output  1  block accepts the result this cycle.
REQ-009 bus_data  output  32  beat driven onto BusMux.
REQ-010 bus_dest  output  2  beat destination: 00=Rz, 01=LO, 10=HI.
REQ-011 bus_valid  output  1  beat valid.
REQ-012 bus_ready  input  1  consumer takes the beat.
REQ-013 Zhigh, Zlow  output  32 each  registered copy of the last accepted result.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 op_err  output  1  one-cycle pulse when an undefined opcode is accepted.

Function
REQ-016 Handshake: transfer in = in_valid & in_ready; transfer out = bus_valid & bus_ready.
REQ-017 Accepted opcodes are 00011-01011, 01111 (mul), 10000 (div), 10001 and 10010.
REQ-018 On transfer in, the block SHALL register ZMuxIn into Zhigh/Zlow and the opcode class; latency from transfer in to bus_valid is 1 cycle.
REQ-019 FSM states: IDLE, BEAT_LO, BEAT_HI.
REQ-020 IDLE -> BEAT_LO on transfer in with a legal opcode.
REQ-021 BEAT_LO, non-mul/div result: drive bus_data=Zlow, bus_dest=00.
REQ-022 BEAT_LO, mul/div result: drive bus_data=Zlow, bus_dest=01; then BEAT_HI drives bus_data=Zhigh, bus_dest=10.
REQ-023 A beat SHALL hold bus_data, bus_dest and bus_valid stable until transfer out.
REQ-024 When bus_ready=0, the current state SHALL persist indefinitely.
REQ-025 Final beat (BEAT_LO for single-beat ops, BEAT_HI for mul/div): on transfer out, go to IDLE, or to BEAT_LO if a new transfer in occurs in the same cycle.
REQ-026 in_ready = (state==IDLE) | (final beat & bus_ready): back-to-back results with no bubble.
REQ-027 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-028 Undefined opcode on transfer in: Zhigh/Zlow SHALL still update, op_err pulses high for 1 cycle, no beats are issued, and the block stays in or returns to IDLE.
REQ-029 Zhigh/Zlow SHALL change only on transfer in.

Reset
REQ-030 Reset values: state=IDLE; Zhigh, Zlow, bus_data=0; bus_dest=00; bus_valid, busy, op_err=0; in_ready=1 in the cycle after reset.
REQ-031 Reset asserted mid-sequence SHALL abandon pending beats, with no further bus_valid until a new transfer in.
REQ-032 Reset SHALL take priority over simultaneous in_valid.

Structure
REQ-033 Shared package: opcode constants (ADD..NOT), the bus_dest encoding, and the FSM state enum, all shared with the ALU and control unit.
REQ-034 One sub-module, z_opcode_decode, SHALL map ALUControl to {legal, is_muldiv}.

Verification
REQ-035 add, ZMuxIn=0x0000_0000_0000_0007, bus_ready=1 -> one beat next cycle: bus_data=0x7, dest=00; busy falls after the beat.
REQ-036 mul, ZMuxIn=0x0000_0001_8000_0000 -> beat LO=0x8000_0000/01, then beat HI=0x0000_0001/10; Zhigh=0x1.
REQ-037 bus_ready held 0 for 5 cycles during BEAT_HI -> bus_data=Zhigh stable throughout; in_ready=0; in_valid pulses ignored.
REQ-038 Back-to-back: sub then or presented on consecutive cycles with bus_ready=1 -> two beats on consecutive cycles, no bubble.
REQ-039 Opcode 11111 -> op_err=1 for exactly one cycle, no bus_valid, Zlow updated.
REQ-040 reset during BEAT_LO of div -> next cycle state=IDLE, bus_valid=0, Zhigh=Zlow=0, no HI beat.
